block_map_writer: RTL and testbench

BLOCK_MAP_WRITER -- requirements
Module: block_map_writer

---
 rtl/block_map_writer.sv | 164 ++++++++++++++++
 tb/tb_block_map_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_writer.sv
// block_map_writer: tile map storage written by a toggle-handshaked command
// word, with an independent registered read port for the display side.
// After reset the map is swept to zero before any command is accepted.
module block_map_writer #(
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int TW   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   cmd_word,
  input  logic [4:0]    rd_col,
  input  logic [3:0]    rd_row,
  output logic [TW-1:0] rd_tile,
  output logic          busy,
  output logic          ack_toggle,
  output logic [7:0]    err_count
);

  localparam int         DEPTH  = COLS * ROWS;
  localparam logic [8:0] COLS_A = 9'(COLS);
  localparam logic [8:0] LAST_A = 9'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WR    = 2'b01,
    SWEEP = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_r;
  logic [8:0]    idx_r;
  logic [8:0]    end_r;
  logic [TW-1:0] val_r;
  logic          last_toggle_r;
  logic          cap_toggle_r;

  logic [TW-1:0] mem_r [0:DEPTH-1];

  logic          cmd_toggle_s;
  logic [1:0]    cmd_op_s;
  logic [4:0]    cmd_col_s;
  logic [3:0]    cmd_row_s;
  logic [TW-1:0] cmd_tile_s;
  logic          col_ok_s;
  logic          row_ok_s;
  logic [8:0]    row_base_s;
  logic [8:0]    wr_addr_s;
  logic          wr_en_s;
  logic          rd_ok_s;
  logic [8:0]    rd_addr_s;

  // Field extraction, range checks and linear address arithmetic
  always_comb begin
    cmd_toggle_s = cmd_word[31];
    cmd_op_s     = cmd_word[30:29];
    cmd_col_s    = cmd_word[12:8];
    cmd_row_s    = cmd_word[7:4];
    cmd_tile_s   = TW'(cmd_word[3:0]);
    col_ok_s     = (32'(cmd_col_s) < COLS);
    row_ok_s     = (32'(cmd_row_s) < ROWS);
    row_base_s   = 9'(cmd_row_s) * COLS_A;
    wr_addr_s    = row_base_s + 9'(cmd_col_s);
    wr_en_s      = (state_r == WR) || (state_r == SWEEP);
    rd_ok_s      = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
    rd_addr_s    = (9'(rd_row) * COLS_A) + 9'(rd_col);
  end

  // Command FSM: detect toggle change in IDLE, run write/sweep, acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= SWEEP;
      idx_r         <= 9'd0;
      end_r         <= LAST_A;
      val_r         <= {TW{1'b0}};
      busy          <= 1'b1;
      last_toggle_r <= 1'b0;
      cap_toggle_r  <= 1'b0;
      ack_toggle    <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_toggle_s != last_toggle_r) begin
            last_toggle_r <= cmd_toggle_s;
            cap_toggle_r  <= cmd_toggle_s;
            val_r         <= cmd_tile_s;
            busy          <= 1'b1;
            case (cmd_op_s)
              2'b00: begin
                if (col_ok_s && row_ok_s) begin
                  idx_r   <= wr_addr_s;
                  state_r <= WR;
                end else begin
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state_r <= DONE;
                end
              end
              2'b01: begin
                idx_r   <= 9'd0;
                end_r   <= LAST_A;
                state_r <= SWEEP;
              end
              2'b10: begin
                if (row_ok_s) begin
                  idx_r   <= row_base_s;
                  end_r   <= row_base_s + COLS_A - 9'd1;
                  state_r <= SWEEP;
                end else begin
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state_r <= DONE;
                end
              end
              default: state_r <= DONE;
            endcase
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        WR: begin
          state_r <= DONE;
          busy    <= 1'b1;
        end
        SWEEP: begin
          busy <= 1'b1;
          if (idx_r == end_r) begin
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + 9'd1;
          end
        end
        DONE: begin
          ack_toggle <= cap_toggle_r;
          state_r    <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Map write port: one location per cycle while writing or sweeping
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_r] <= val_r;
    end
  end

  // Registered read port; old data on same-address write, zero when out of range
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_tile <= {TW{1'b0}};
    end else if (rd_ok_s) begin
      rd_tile <= mem_r[rd_addr_s];
    end else begin
      rd_tile <= {TW{1'b0}};
    end
  end

endmodule

// File: tb/tb_block_map_writer.sv
// Self-checking bench for block_map_writer: spec vectors from a table,
// randomized commands against a map-level reference model, plus hand-written
// multi-cycle corner cases (read/write collision, toggle glitch, error
// saturation, reset during a clear).
module tb_block_map_writer;

  logic        clk;
  logic        reset_n;
  logic [31:0] cmd_word;
  logic [4:0]  rd_col;
  logic [3:0]  rd_row;
  logic [3:0]  rd_tile;
  logic        busy;
  logic        ack_toggle;
  logic [7:0]  err_count;

  block_map_writer #(.COLS(20), .ROWS(15), .TW(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_word(cmd_word),
    .rd_col(rd_col), .rd_row(rd_row), .rd_tile(rd_tile),
    .busy(busy), .ack_toggle(ack_toggle), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [3:0] m_map [300];
  logic       m_last;
  logic       m_ack;
  int         m_err;

  typedef struct {
    logic [31:0] word;
    int          exp_cyc;
    logic        exp_ack;
    int          exp_err;
    int          r0, c0, t0;
    int          r1, c1, t1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 300; a++) m_map[a] = 4'd0;
    m_last = 1'b0;
    m_ack  = 1'b0;
    m_err  = 0;
  endtask

  // map-level effect of one command word seen while idle; returns busy length
  task automatic model_apply(input logic [31:0] w, output int cyc);
    int op, col, row;
    logic [3:0] t;
    op  = int'(w[30:29]);
    col = int'(w[12:8]);
    row = int'(w[7:4]);
    t   = w[3:0];
    if (w[31] == m_last) begin
      cyc = 0;
    end else begin
      m_last = w[31];
      m_ack  = w[31];
      if (op == 0) begin
        if (col < 20 && row < 15) begin
          m_map[row * 20 + col] = t;
          cyc = 2;
        end else begin
          if (m_err < 255) m_err++;
          cyc = 1;
        end
      end else if (op == 1) begin
        for (int a = 0; a < 300; a++) m_map[a] = t;
        cyc = 301;
      end else if (op == 2) begin
        if (row < 15) begin
          for (int c = 0; c < 20; c++) m_map[row * 20 + c] = t;
          cyc = 21;
        end else begin
          if (m_err < 255) m_err++;
          cyc = 1;
        end
      end else begin
        cyc = 1;
      end
    end
  endtask

  // count rising edges until busy is seen low, bounded
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // present a command word while idle; busy length counted after the detection edge
  task automatic run_cmd(input logic [31:0] w, output int cyc);
    @(negedge clk);
    cmd_word = w;
    @(posedge clk); #1;
    wait_idle(cyc);
  endtask

  task automatic read_at(input int r, input int c, output int v);
    @(negedge clk);
    rd_row = 4'(r);
    rd_col = 5'(c);
    @(posedge clk); #1;
    v = int'(rd_tile);
  endtask

  task automatic scan(input string name);
    int v, bad, first_bad;
    bad = 0;
    first_bad = -1;
    for (int a = 0; a < 300; a++) begin
      read_at(a / 20, a % 20, v);
      if (v != int'(m_map[a])) begin
        if (first_bad < 0) first_bad = a;
        bad++;
      end
    end
    if (bad != 0) $display("  scan %s: first bad address %0d", name, first_bad);
    check(name, bad, 0);
  endtask

  initial begin
    int cyc, exp_cyc, v, extra, old_t, new_t;
    logic [31:0] w;

    vecs[0] = '{32'h80000537,   2, 1'b1, 0,  3,  5,  7,  3,  4,  0};
    vecs[1] = '{32'h2000000A, 301, 1'b0, 0,  3,  5, 10, 14, 19, 10};
    vecs[2] = '{32'hC0000F51,  21, 1'b1, 0,  5, 19,  1,  4,  0, 10};
    vecs[3] = '{32'h00001937,   1, 1'b0, 1,  3,  5, 10,  5,  5,  1};
    vecs[4] = '{32'hE0000000,   1, 1'b1, 1,  0,  0, 10,  5,  0,  1};
    vecs[5] = '{32'hE0000000,   0, 1'b1, 1,  5, 10,  1,  6, 10, 10};
    vecs[6] = '{32'h400000F3,   1, 1'b0, 2, 14,  0, 10,  0, 19, 10};
    vecs[7] = '{32'h800000F2,   1, 1'b1, 3,  0,  0, 10, 14,  0, 10};
    vecs[8] = '{32'h000013E9,   2, 1'b0, 3, 14, 19,  9, 14, 18, 10};
    vecs[9] = '{32'hC0FF1FE2,  21, 1'b1, 3, 14,  0,  2, 14, 19,  2};

    reset_n  = 1'b0;
    cmd_word = 32'd0;
    rd_row   = 4'd0;
    rd_col   = 5'd0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 1);
    check("reset_ack", int'(ack_toggle), 0);
    check("reset_err", int'(err_count), 0);
    check("reset_rd_tile", int'(rd_tile), 0);

    // auto-clear after release
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle(cyc);
    check("autoclear_busy_cycles", cyc, 301);
    check("autoclear_ack", int'(ack_toggle), 0);
    scan("autoclear_map_zero");

    // table-driven spec vectors
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].word, cyc);
      model_apply(vecs[i].word, exp_cyc);
      check($sformatf("vec%0d_busy", i), cyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_ack", i), int'(ack_toggle), int'(vecs[i].exp_ack));
      check($sformatf("vec%0d_err", i), int'(err_count), vecs[i].exp_err);
      read_at(vecs[i].r0, vecs[i].c0, v);
      check($sformatf("vec%0d_rd0", i), v, vecs[i].t0);
      read_at(vecs[i].r1, vecs[i].c1, v);
      check($sformatf("vec%0d_rd1", i), v, vecs[i].t1);
    end
    scan("table_map");

    // out-of-range reads return 0
    read_at(15, 3, v);
    check("oor_read_row15", v, 0);
    read_at(2, 25, v);
    check("oor_read_col25", v, 0);
    read_at(15, 31, v);
    check("oor_read_both", v, 0);

    // read and write to the same address in the same cycle: old data first
    old_t = int'(m_map[7 * 20 + 7]);
    new_t = (old_t + 1) % 16;
    w = {~m_last, 2'b00, 16'd0, 5'd7, 4'd7, 4'(new_t)};
    @(negedge clk);
    cmd_word = w;
    rd_row = 4'd7;
    rd_col = 5'd7;
    @(posedge clk);
    @(posedge clk); #1;
    check("rw_collision_old", int'(rd_tile), old_t);
    @(posedge clk); #1;
    check("rw_collision_new", int'(rd_tile), new_t);
    wait_idle(cyc);
    model_apply(w, exp_cyc);
    check("rw_collision_ack", int'(ack_toggle), int'(m_ack));

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic       tog;
      op  = 2'($urandom_range(0, 3));
      if (op == 2'b01 && $urandom_range(0, 3) != 0) op = 2'b11;
      tog = ($urandom_range(0, 7) == 0) ? m_last : ~m_last;
      w = {tog, op, 16'($urandom), 5'($urandom_range(0, 22)),
           4'($urandom_range(0, 15)), 4'($urandom)};
      run_cmd(w, cyc);
      model_apply(w, exp_cyc);
      check($sformatf("rand%0d_busy w=%h", i, w), cyc, exp_cyc);
      check($sformatf("rand%0d_ack", i), int'(ack_toggle), int'(m_ack));
      check($sformatf("rand%0d_err", i), int'(err_count), m_err);
      begin
        int r, c;
        r = $urandom_range(0, 14);
        c = $urandom_range(0, 19);
        read_at(r, c, v);
        check($sformatf("rand%0d_rd(%0d,%0d)", i, r, c), v, int'(m_map[r * 20 + c]));
      end
    end
    scan("random_map");

    // toggle flipped twice during a clear: nothing extra afterwards
    w = {~m_last, 2'b01, 16'd0, 5'd0, 4'd0, 4'd3};
    @(negedge clk);
    cmd_word = w;
    @(posedge clk); #1;
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 50) cmd_word = w ^ 32'h80000000;
      if (cyc == 60) cmd_word = w;
    end
    model_apply(w, exp_cyc);
    check("glitch_clear_busy", cyc, 301);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy) extra++;
    end
    check("glitch_no_extra_cmd", extra, 0);
    check("glitch_ack", int'(ack_toggle), int'(m_ack));
    scan("glitch_map");

    // error counter saturation
    for (int i = 0; i < 256; i++) begin
      w = {~m_last, 2'b00, 16'd0, 5'd25, 4'd3, 4'd7};
      run_cmd(w, cyc);
      model_apply(w, exp_cyc);
    end
    check("err_saturated", int'(err_count), 255);
    check("err_sat_ack", int'(ack_toggle), int'(m_ack));
    w = {~m_last, 2'b10, 16'd0, 5'd0, 4'd15, 4'd7};
    run_cmd(w, cyc);
    model_apply(w, exp_cyc);
    check("err_hold_busy", cyc, 1);
    check("err_hold_255", int'(err_count), 255);
    scan("err_map_unchanged");

    // reset in the middle of a clear restarts the auto-clear
    w = {~m_last, 2'b01, 16'd0, 5'd0, 4'd0, 4'd5};
    @(negedge clk);
    cmd_word = w;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 1);
    check("midreset_err", int'(err_count), 0);
    check("midreset_ack", int'(ack_toggle), 0);
    cmd_word = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    wait_idle(cyc);
    check("midreset_busy_cycles", cyc, 301);
    scan("midreset_map_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
